mcmc_proposal_unit: RTL and testbench
=====================================

// Module: mcmc_proposal_unit
// PURPOSE
// - Proposal stage of the MCMC solver, directly downstream of RandomGenerator.
// - Holds NUM_VARS signed variables; per iteration requests one random step in [-STEP,STEP] from RandomGenerator.
// - Adds the step to the round-robin selected variable and bounds the result to [VAR_MIN,VAR_MAX].
// - Offers the proposal to the constraint evaluator (valid/ready); commits or discards it on the returned accept/reject.
// PARAMETERS
// - NUM_VARS  4    number of variables; index width IDXW = $clog2(NUM_VARS), minimum 1
// - WIDTH     8    signed variable width; the random path is fixed at 8 bits
// - STEP      3    maximum step magnitude, 1..127
// - VAR_MIN  -64   lower variable bound; must satisfy VAR_MIN <= 0 <= VAR_MAX
// - VAR_MAX   63   upper variable bound
// PORTS
// - in_clock          in   1      system clock, all logic on posedge
// - in_reset          in   1      synchronous, active-high
// - in_start          in   1      begin one iteration; honoured only in IDLE
// - in_load           in   1      write in_load_value to var[in_load_idx]; honoured only in IDLE
// - in_load_idx       in   IDXW   load target index
// - in_load_value     in   WIDTH  signed load value; clamped to bounds on write
// - out_rand_enable   out  1      drives RandomGenerator in_enable
// - out_rand_min      out  8      constant -STEP, drives RandomGenerator in_min
// - out_rand_max      out  8      constant +STEP, drives RandomGenerator in_max
// - in_random         in   8      signed RandomGenerator out_random
// - out_prop_valid    out  1      proposal valid
// - in_prop_ready     in   1      evaluator accepts proposal
// - out_prop_idx      out  IDXW   index of the proposed variable
// - out_prop_value    out  WIDTH  proposed (bounded) value
// - out_prop_old      out  WIDTH  current value of that variable
// - in_decision_valid in   1      evaluator decision strobe
// - in_accept         in   1      1 = commit proposal, 0 = discard
// - out_busy          out  1      high in every state except IDLE
// - out_accept_count  out  16     number of accepted proposals, saturates at 16'hFFFF
// BEHAVIOUR
// - Reset (synchronous): state IDLE; all vars 0; idx 0; accept_count 0; out_rand_enable, out_prop_valid, out_busy 0; out_prop_* 0.
// - FSM: IDLE -> REQ -> CAPTURE -> PROPOSE -> DECIDE -> IDLE.
// - IDLE: in_start=1 -> REQ. If in_start and in_load are both high, the load is performed and start is taken in the same cycle.
// - REQ: out_rand_enable=1 for exactly this one cycle; -> CAPTURE.
// - CAPTURE: in_random is sampled as delta (valid after the REQ edge).
//   - sum = sign-extended var[idx] + sign-extended delta, computed at WIDTH+1 bits, no overflow.
//   - sum is bounded (see CONFIGURATION) and registered into out_prop_value/out_prop_old/out_prop_idx; -> PROPOSE.
// - PROPOSE: out_prop_valid=1 with payload held stable until in_prop_ready=1; that edge -> DECIDE, valid drops.
// - DECIDE: waits for in_decision_valid.
//   - in_accept=1: var[idx] <= out_prop_value; accept_count+1 (saturating).
//   - in_accept=0: vars unchanged.
//   - Either way idx advances, NUM_VARS-1 wraps to 0; -> IDLE.
// - Latency: start to out_prop_valid = 3 cycles; minimum iteration = 5 cycles.
// - Decision strobes outside DECIDE are ignored, including one in the cycle of the PROPOSE handshake.
// - in_start/in_load outside IDLE are ignored.
// - in_reset in any state overrides everything next edge; no partial commit.
// CONFIGURATION
// - Macro PROPOSAL_REFLECT_EN.
//   - Undefined (default): saturation; sum > VAR_MAX -> VAR_MAX, sum < VAR_MIN -> VAR_MIN.
//   - Defined: reflection; sum > VAR_MAX -> 2*VAR_MAX - sum, sum < VAR_MIN -> 2*VAR_MIN - sum.
//     A reflected result still out of range (STEP > VAR_MAX-VAR_MIN) is then saturated.
// - Ports and timing are identical in both builds.
// TESTING
// - Reset, then load var[2]=10, start x3 with in_random=+2 and accept -> var[0]=var[1]=2, var[2]=12, accept_count=3.
// - var[0]=62, in_random=+3 -> out_prop_value=63 (default); 61 with PROPOSAL_REFLECT_EN.
// - var[0]=-63, in_random=-3 -> -64 (default); -62 with PROPOSAL_REFLECT_EN; reject leaves var[0]=-63, accept_count unchanged.
// - Hold in_prop_ready=0 for 7 cycles -> valid and payload stable; decision strobes during PROPOSE are ignored; ready=1 -> DECIDE.
// - Load 100 -> stored 63; load -100 -> stored -64; 4 iterations make idx wrap 3->0; start/load while busy are ignored.
// - Assert in_reset during PROPOSE -> next cycle IDLE, vars 0, out_prop_valid 0, out_rand_enable 0, accept_count 0.

Source files
------------

// File: rtl/mcmc_proposal_unit_if.sv
// rtl/mcmc_proposal_unit_if.sv - control, random-source and proposal/decision signals of the proposal stage
interface mcmc_proposal_unit_if #(
  parameter int NUM_VARS = 4,
  parameter int WIDTH    = 8
);
  localparam int IDXW = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;

  logic             in_start;
  logic             in_load;
  logic [IDXW-1:0]  in_load_idx;
  logic [WIDTH-1:0] in_load_value;
  logic             out_rand_enable;
  logic [7:0]       out_rand_min;
  logic [7:0]       out_rand_max;
  logic [7:0]       in_random;
  logic             out_prop_valid;
  logic             in_prop_ready;
  logic [IDXW-1:0]  out_prop_idx;
  logic [WIDTH-1:0] out_prop_value;
  logic [WIDTH-1:0] out_prop_old;
  logic             in_decision_valid;
  logic             in_accept;
  logic             out_busy;
  logic [15:0]      out_accept_count;

  modport slave (
    input  in_start, in_load, in_load_idx, in_load_value, in_random,
           in_prop_ready, in_decision_valid, in_accept,
    output out_rand_enable, out_rand_min, out_rand_max, out_prop_valid,
           out_prop_idx, out_prop_value, out_prop_old, out_busy, out_accept_count
  );

  modport master (
    output in_start, in_load, in_load_idx, in_load_value, in_random,
           in_prop_ready, in_decision_valid, in_accept,
    input  out_rand_enable, out_rand_min, out_rand_max, out_prop_valid,
           out_prop_idx, out_prop_value, out_prop_old, out_busy, out_accept_count
  );
endinterface

// File: rtl/mcmc_proposal_unit.sv
// rtl/mcmc_proposal_unit.sv - MCMC proposal stage: random step on a round-robin variable, bound, offer, commit/discard
// PROPOSAL_REFLECT_EN selects reflection at the bounds instead of saturation.
module mcmc_proposal_unit #(
  parameter int NUM_VARS = 4,
  parameter int WIDTH    = 8,
  parameter int STEP     = 3,
  parameter int VAR_MIN  = -64,
  parameter int VAR_MAX  = 63
) (
  input logic in_clock,
  input logic in_reset,
  mcmc_proposal_unit_if.slave bus
);
  localparam int IDXW = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
  // Headroom for var+delta and for the doubled bound used by reflection
  localparam int SW = ((WIDTH > 8) ? WIDTH : 8) + 3;
  localparam logic signed [SW-1:0] LO = SW'(VAR_MIN);
  localparam logic signed [SW-1:0] HI = SW'(VAR_MAX);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_VARS - 1);

  typedef enum logic [2:0] {IDLE, REQ, CAPTURE, PROPOSE, DECIDE} state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] vars [NUM_VARS];
  logic [IDXW-1:0]         idx;
  logic [15:0]             accept_count;
  logic signed [SW-1:0]    cur_ext;
  logic signed [SW-1:0]    delta_ext;
  logic signed [SW-1:0]    load_ext;

  function automatic logic signed [WIDTH-1:0] saturate(input logic signed [SW-1:0] v);
    if (v > HI) return HI[WIDTH-1:0];
    if (v < LO) return LO[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] bound_sum(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] r;
    r = s;
`ifdef PROPOSAL_REFLECT_EN
    if (s > HI)      r = (HI <<< 1) - s;
    else if (s < LO) r = (LO <<< 1) - s;
`endif
    return saturate(r);
  endfunction

  assign cur_ext   = SW'(vars[idx]);
  assign delta_ext = SW'($signed(bus.in_random));
  assign load_ext  = SW'($signed(bus.in_load_value));

  assign bus.out_rand_min     = 8'(-STEP);
  assign bus.out_rand_max     = 8'(STEP);
  assign bus.out_accept_count = accept_count;

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state               <= IDLE;
      idx                 <= '0;
      accept_count        <= '0;
      for (int i = 0; i < NUM_VARS; i++) vars[i] <= '0;
      bus.out_rand_enable <= 1'b0;
      bus.out_prop_valid  <= 1'b0;
      bus.out_busy        <= 1'b0;
      bus.out_prop_idx    <= '0;
      bus.out_prop_value  <= '0;
      bus.out_prop_old    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_load) vars[bus.in_load_idx] <= saturate(load_ext);
          if (bus.in_start) begin
            state               <= REQ;
            bus.out_rand_enable <= 1'b1;
            bus.out_busy        <= 1'b1;
          end
        end
        REQ: begin
          bus.out_rand_enable <= 1'b0;
          state               <= CAPTURE;
        end
        CAPTURE: begin
          bus.out_prop_value <= bound_sum(cur_ext + delta_ext);
          bus.out_prop_old   <= vars[idx];
          bus.out_prop_idx   <= idx;
          bus.out_prop_valid <= 1'b1;
          state              <= PROPOSE;
        end
        PROPOSE: begin
          if (bus.in_prop_ready) begin
            bus.out_prop_valid <= 1'b0;
            state              <= DECIDE;
          end
        end
        DECIDE: begin
          if (bus.in_decision_valid) begin
            if (bus.in_accept) begin
              vars[idx] <= bus.out_prop_value;
              if (accept_count != 16'hFFFF) accept_count <= accept_count + 16'd1;
            end
            idx          <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            bus.out_busy <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mcmc_proposal_unit.sv
// tb/tb_mcmc_proposal_unit.sv - randomized bench for mcmc_proposal_unit with a transaction-level model
module tb_mcmc_proposal_unit;
  localparam int VMIN = -64;
  localparam int VMAX = 63;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mcmc_proposal_unit_if #(.NUM_VARS(4), .WIDTH(8)) bus ();

  mcmc_proposal_unit #(
    .NUM_VARS(4), .WIDTH(8), .STEP(3), .VAR_MIN(-64), .VAR_MAX(63)
  ) dut (
    .in_clock(clk),
    .in_reset(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m_vars [4];
  int m_idx, m_count;
  bit exp_busy, exp_ren, exp_valid;
  int exp_idx, exp_val, exp_old;
  bit chk_en = 0;
  int last_val, last_old, last_idx;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int clampv(input int v);
    if (v > VMAX) return VMAX;
    if (v < VMIN) return VMIN;
    return v;
  endfunction

  function automatic int bound(input int s);
    int r;
    r = s;
`ifdef PROPOSAL_REFLECT_EN
    if (s > VMAX)      r = 2 * VMAX - s;
    else if (s < VMIN) r = 2 * VMIN - s;
`endif
    return clampv(r);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(bus.out_busy), int'(exp_busy));
      check("rand_enable", int'(bus.out_rand_enable), int'(exp_ren));
      check("prop_valid", int'(bus.out_prop_valid), int'(exp_valid));
      check("accept_count", int'(bus.out_accept_count), m_count);
      if (exp_valid) begin
        check("prop_idx", int'(bus.out_prop_idx), exp_idx);
        check("prop_value", int'($signed(bus.out_prop_value)), exp_val);
        check("prop_old", int'($signed(bus.out_prop_old)), exp_old);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_vars[i] = 0;
    m_idx = 0; m_count = 0;
    exp_busy = 0; exp_ren = 0; exp_valid = 0;
  endtask

  task automatic load(input int lidx, input int lval);
    bus.in_load = 1'b1; bus.in_load_idx = 2'(lidx); bus.in_load_value = 8'(lval);
    tick();
    bus.in_load = 1'b0;
    m_vars[lidx] = clampv(lval);
  endtask

  task automatic iter(input int delta, input bit acc, input int rdy_dly = 0, input int dec_dly = 0,
                      input bit strobes = 0, input bit poke = 0,
                      input bit do_load = 0, input int lidx = 0, input int lval = 0);
    bus.in_start = 1'b1;
    if (do_load) begin
      bus.in_load = 1'b1; bus.in_load_idx = 2'(lidx); bus.in_load_value = 8'(lval);
    end
    tick();
    bus.in_start = 1'b0; bus.in_load = 1'b0;
    if (do_load) m_vars[lidx] = clampv(lval);
    exp_busy = 1; exp_ren = 1;
    bus.in_random = 8'($urandom_range(0, 255));
    tick();
    exp_ren = 0;
    bus.in_random = 8'(delta);
    tick();
    bus.in_random = 8'($urandom_range(0, 255));
    exp_valid = 1; exp_idx = m_idx; exp_old = m_vars[m_idx]; exp_val = bound(m_vars[m_idx] + delta);
    last_val = int'($signed(bus.out_prop_value));
    last_old = int'($signed(bus.out_prop_old));
    last_idx = int'(bus.out_prop_idx);
    for (int i = 0; i < rdy_dly; i++) begin
      if (strobes) begin bus.in_decision_valid = 1'b1; bus.in_accept = 1'b1; end
      if (poke) begin
        bus.in_start = 1'b1; bus.in_load = 1'b1;
        bus.in_load_idx = 2'(m_idx); bus.in_load_value = 8'($urandom_range(0, 255));
      end
      tick();
      bus.in_decision_valid = 1'b0; bus.in_start = 1'b0; bus.in_load = 1'b0;
    end
    bus.in_prop_ready = 1'b1;
    if (strobes) begin bus.in_decision_valid = 1'b1; bus.in_accept = 1'b1; end
    tick();
    bus.in_prop_ready = 1'b0; bus.in_decision_valid = 1'b0;
    exp_valid = 0;
    for (int i = 0; i < dec_dly; i++) begin
      if (poke) begin bus.in_start = 1'b1; bus.in_load = 1'b1; end
      tick();
      bus.in_start = 1'b0; bus.in_load = 1'b0;
    end
    bus.in_decision_valid = 1'b1; bus.in_accept = acc;
    tick();
    bus.in_decision_valid = 1'b0; bus.in_accept = 1'b0;
    if (acc) begin
      m_vars[m_idx] = exp_val;
      if (m_count < 65535) m_count++;
    end
    m_idx = (m_idx + 1) % 4;
    exp_busy = 0;
  endtask

  initial begin
    bus.in_start = 0; bus.in_load = 0; bus.in_load_idx = 0; bus.in_load_value = 0;
    bus.in_random = 0; bus.in_prop_ready = 0; bus.in_decision_valid = 0; bus.in_accept = 0;
    model_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk_en = 1;

    check("reset_busy", int'(bus.out_busy), 0);
    check("reset_valid", int'(bus.out_prop_valid), 0);
    check("reset_rand_enable", int'(bus.out_rand_enable), 0);
    check("reset_count", int'(bus.out_accept_count), 0);
    check("reset_prop_value", int'(bus.out_prop_value), 0);
    check("reset_prop_old", int'(bus.out_prop_old), 0);
    check("reset_prop_idx", int'(bus.out_prop_idx), 0);
    check("rand_min", int'($signed(bus.out_rand_min)), -3);
    check("rand_max", int'($signed(bus.out_rand_max)), 3);

    load(2, 10);
    iter(2, 1); iter(2, 1); iter(2, 1);
    check("pin_var2_step", last_val, 12);
    check("pin_count3", int'(bus.out_accept_count), 3);
    iter(0, 0);
    iter(0, 0); check("pin_var0", last_old, 2);
    iter(0, 0); check("pin_var1", last_old, 2);
    iter(0, 0); check("pin_var2", last_old, 12);
    iter(0, 0); check("pin_idx3", last_idx, 3);

    load(0, 62);
    iter(3, 0);
    check("pin_wrap_idx0", last_idx, 0);
`ifdef PROPOSAL_REFLECT_EN
    check("pin_upper_bound", last_val, 61);
`else
    check("pin_upper_bound", last_val, 63);
`endif

    load(0, -63);
    load(1, 100);
    load(2, -100);
    iter(0, 0); check("pin_load_clamp_hi", last_old, 63);
    iter(0, 0); check("pin_load_clamp_lo", last_old, -64);
    iter(1, 0, 7, 2, 1, 1);
    check("pin_strobes_ignored", int'(bus.out_accept_count), 3);
    iter(-3, 0);
    check("pin_lower_old", last_old, -63);
`ifdef PROPOSAL_REFLECT_EN
    check("pin_lower_bound", last_val, -62);
`else
    check("pin_lower_bound", last_val, -64);
`endif
    check("pin_reject_count", int'(bus.out_accept_count), 3);
    iter(0, 0); iter(0, 0); iter(0, 0);
    iter(0, 1);
    check("pin_reject_kept", last_old, -63);
    check("pin_count4", int'(bus.out_accept_count), 4);

    for (int n = 0; n < 40; n++) begin
      iter(int'($urandom_range(0, 6)) - 3, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 255)) - 128);
      repeat ($urandom_range(0, 2)) tick();
    end

    bus.in_start = 1'b1;
    tick();
    bus.in_start = 1'b0;
    exp_busy = 1; exp_ren = 1;
    tick();
    exp_ren = 0; bus.in_random = 8'd2;
    tick();
    exp_valid = 1; exp_idx = m_idx; exp_old = m_vars[m_idx]; exp_val = bound(m_vars[m_idx] + 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("rst_busy", int'(bus.out_busy), 0);
    check("rst_valid", int'(bus.out_prop_valid), 0);
    check("rst_rand_enable", int'(bus.out_rand_enable), 0);
    check("rst_count", int'(bus.out_accept_count), 0);
    iter(1, 1);
    check("pin_rst_idx", last_idx, 0);
    check("pin_rst_var", last_old, 0);
    check("pin_rst_value", last_val, 1);
    check("pin_rst_count1", int'(bus.out_accept_count), 1);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
